// File: rtl/csa_stream_sched.sv
// csa_stream_sched: shares one registered 8-byte CSA stream pipeline among
// NCH descrambler channels. Each channel keeps its own 107-bit stream state;
// one block is issued per cycle, with channels picked round-robin.
// Returned state is written back when its tag reaches depth ST_LAT. The cipher
// bytes are registered out, tagged with their channel, when the CB tag
// reaches depth CB_LAT.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   ld_valid/ld_ch/ld_state  channel state load; ld_ready = target not busy
//   req_valid/first/sb       per-channel block requests (sb: 64 bits/channel)
//   req_ready                one-hot grant (combinational)
//   pl_init/pl_sb/pl_state_o registered pipeline inputs
//   pl_state_i/pl_cb         pipeline outputs
//   cb_valid/cb_ch/cb_data   tagged cipher-byte output (no backpressure)
//   busy                     per-channel in-flight flag

// Per-channel slot: stream state, loaded flag and in-flight flag.
module csa_ch_slot (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_we,
  input  logic [106:0] ld_state,
  input  logic         wb_we,
  input  logic [106:0] wb_state,
  input  logic         grant,
  output logic [106:0] state,
  output logic         loaded,
  output logic         busy
);
  // A load and a writeback never target the same channel in one cycle,
  // because a load requires ~busy and a writeback implies busy.
  always_ff @(posedge clk) begin
    if (ld_we)      state <= ld_state;
    else if (wb_we) state <= wb_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded <= 1'b0;
      busy   <= 1'b0;
    end else begin
      if (ld_we) loaded <= 1'b1;
      // A grant can only reach an idle channel, so it never collides with wb.
      if (grant)      busy <= 1'b1;
      else if (wb_we) busy <= 1'b0;
    end
  end
endmodule

module csa_stream_sched #(
  parameter  int NCH    = 4,
  parameter  int ST_LAT = 9,
  parameter  int CB_LAT = 16,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_valid,
  input  logic [CW-1:0]      ld_ch,
  input  logic [106:0]       ld_state,
  output logic               ld_ready,
  input  logic [NCH-1:0]     req_valid,
  input  logic [NCH-1:0]     req_first,
  input  logic [NCH*64-1:0]  req_sb,
  output logic [NCH-1:0]     req_ready,
  output logic               pl_init,
  output logic [63:0]        pl_sb,
  output logic [106:0]       pl_state_o,
  input  logic [106:0]       pl_state_i,
  input  logic [63:0]        pl_cb,
  output logic               cb_valid,
  output logic [CW-1:0]      cb_ch,
  output logic [63:0]        cb_data,
  output logic [NCH-1:0]     busy
);
  typedef struct packed {
    logic          v;
    logic [CW-1:0] ch;
  } tag_t;

  logic [NCH-1:0][106:0] state;
  logic [NCH-1:0]        loaded, ld_hit, ld_we, wb_we, elig, gnt;
  logic [CW-1:0]         rr, gidx;
  logic                  found;
  tag_t [ST_LAT:1]       st_pipe;
  tag_t [CB_LAT:1]       cb_pipe;

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      assign ld_hit[c] = ld_valid && (ld_ch == CW'(c));
      assign ld_we[c]  = ld_hit[c] && !busy[c];
      assign wb_we[c]  = st_pipe[ST_LAT].v && (st_pipe[ST_LAT].ch == CW'(c));
      // A channel being loaded this cycle is skipped; the load wins.
      assign elig[c]   = req_valid[c] && loaded[c] && !busy[c] && !ld_hit[c];

      csa_ch_slot u_slot (
        .clk      (clk),
        .rst      (rst),
        .ld_we    (ld_we[c]),
        .ld_state (ld_state),
        .wb_we    (wb_we[c]),
        .wb_state (pl_state_i),
        .grant    (gnt[c]),
        .state    (state[c]),
        .loaded   (loaded[c]),
        .busy     (busy[c])
      );
    end
  endgenerate

  // Out-of-range ld_ch matches no channel: ready stays high and nothing is written.
  always_comb begin
    ld_ready = 1'b1;
    for (int i = 0; i < NCH; i++)
      if (ld_ch == CW'(i)) ld_ready = !busy[i];
  end

  // Round-robin search that starts at rr and wraps.
  always_comb begin
    int j;
    j     = 0;
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      j = int'(rr) + i;
      if (j >= NCH) j = j - NCH;
      if (!found && elig[j]) begin
        found  = 1'b1;
        gidx   = CW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

  assign req_ready = gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr         <= '0;
      pl_init    <= 1'b0;
      pl_sb      <= '0;
      pl_state_o <= '0;
      st_pipe    <= '0;
      cb_pipe    <= '0;
      cb_valid   <= 1'b0;
      cb_ch      <= '0;
      cb_data    <= '0;
    end else begin
      pl_init <= 1'b0;
      if (found) begin
        rr         <= (int'(gidx) == NCH - 1) ? '0 : gidx + 1'b1;
        pl_init    <= req_first[gidx];
        pl_sb      <= req_sb[int'(gidx)*64 +: 64];
        pl_state_o <= state[gidx];
      end
      // Tags enter at depth 1 together with the issue registers.
      st_pipe[1] <= '{v: found, ch: gidx};
      for (int i = 2; i <= ST_LAT; i++) st_pipe[i] <= st_pipe[i-1];
      cb_pipe[1] <= '{v: found, ch: gidx};
      for (int i = 2; i <= CB_LAT; i++) cb_pipe[i] <= cb_pipe[i-1];

      cb_valid <= cb_pipe[CB_LAT].v;
      if (cb_pipe[CB_LAT].v) begin
        cb_ch   <= cb_pipe[CB_LAT].ch;
        cb_data <= pl_cb;
      end
    end
  end
endmodule

// File: tb/tb_csa_stream_sched.sv
// Randomized bench for csa_stream_sched. A stand-in pipeline (delay line plus
// a simple bijective mix) feeds pl_state_i/pl_cb. A cycle-level reference
// model tracks per-channel state, loaded and in-flight flags (each with its
// writeback cycle), the round-robin pointer, and a queue of expected outputs.
module tb_csa_stream_sched;
  localparam int NCH = 4, ST_LAT = 9, CB_LAT = 16, CW = 2;

  logic              clk = 1'b0, rst = 1'b1;
  logic              ld_valid, ld_ready;
  logic [CW-1:0]     ld_ch;
  logic [106:0]      ld_state;
  logic [NCH-1:0]    req_valid, req_first, req_ready, busy;
  logic [NCH*64-1:0] req_sb;
  logic              pl_init, cb_valid;
  logic [63:0]       pl_sb, pl_cb, cb_data;
  logic [106:0]      pl_state_o, pl_state_i;
  logic [CW-1:0]     cb_ch;

  csa_stream_sched #(.NCH(NCH), .ST_LAT(ST_LAT), .CB_LAT(CB_LAT)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ch(ld_ch), .ld_state(ld_state), .ld_ready(ld_ready),
    .req_valid(req_valid), .req_first(req_first), .req_sb(req_sb), .req_ready(req_ready),
    .pl_init(pl_init), .pl_sb(pl_sb), .pl_state_o(pl_state_o),
    .pl_state_i(pl_state_i), .pl_cb(pl_cb),
    .cb_valid(cb_valid), .cb_ch(cb_ch), .cb_data(cb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [106:0] f_st(logic [106:0] s, logic [63:0] sb, logic init);
    return {s[105:0], s[106]} ^ {43'd0, sb} ^ (init ? 107'h1_2345 : 107'd0);
  endfunction

  function automatic logic [63:0] f_cb(logic [106:0] s, logic [63:0] sb, logic init);
    return s[63:0] ^ {sb[31:0], sb[63:32]} ^ (init ? 64'hC3 : 64'h0) ^ 64'h0F0F_0000_0000_00F0;
  endfunction

  // Stand-in pipeline: stage k holds the issue values from k cycles earlier.
  logic [171:0] dl [1:CB_LAT-1];
  always @(posedge clk) begin
    dl[1] <= {pl_init, pl_sb, pl_state_o};
    for (int i = 2; i < CB_LAT; i++) dl[i] <= dl[i-1];
  end
  assign pl_state_i = f_st(dl[ST_LAT-1][106:0], dl[ST_LAT-1][170:107], dl[ST_LAT-1][171]);
  assign pl_cb      = f_cb(dl[CB_LAT-1][106:0], dl[CB_LAT-1][170:107], dl[CB_LAT-1][171]);

  int n_chk = 0, n_pass = 0, cyc = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  // Reference model
  typedef struct { int cyc; int ch; logic [63:0] d; } cbe_t;
  cbe_t         cbq[$];
  bit           m_loaded[NCH], m_busy[NCH];
  int           m_wb[NCH];
  logic [106:0] m_state[NCH], m_ret[NCH];
  int           m_rr;
  bit           exp_iss;
  logic         exp_init;
  logic [63:0]  exp_sb;
  logic [106:0] exp_st;

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_loaded[c] = 0; m_busy[c] = 0; m_wb[c] = 0;
    end
    m_rr = 0; exp_iss = 0; cbq.delete();
  endtask

  // Called at the negedge of cycle cyc: check outputs, then apply the edge.
  task automatic step();
    logic [NCH-1:0] elig, exp_busy, exp_gnt;
    logic [63:0]    sb;
    int             g, c2;
    bit             ld_ok;
    for (int c = 0; c < NCH; c++) begin
      exp_busy[c] = m_busy[c];
      elig[c] = req_valid[c] && m_loaded[c] && !m_busy[c] && !(ld_valid && int'(ld_ch) == c);
    end
    g = -1;
    for (int i = 0; i < NCH; i++) begin
      c2 = (m_rr + i) % NCH;
      if (g < 0 && elig[c2]) g = c2;
    end
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;

    chk("busy", busy, exp_busy);
    chk("req_ready", req_ready, exp_gnt);
    chk("ld_ready", ld_ready, !m_busy[ld_ch]);
    if (exp_iss) begin
      chk("pl_init", pl_init, exp_init);
      chk("pl_sb", pl_sb, exp_sb);
      chk("pl_state_o", pl_state_o, exp_st);
    end else chk("pl_init_idle", pl_init, 1'b0);
    if (cbq.size() > 0 && cbq[0].cyc == cyc) begin
      chk("cb_valid", cb_valid, 1'b1);
      chk("cb_ch", cb_ch, cbq[0].ch);
      chk("cb_data", cb_data, cbq[0].d);
      void'(cbq.pop_front());
    end else chk("cb_valid_idle", cb_valid, 1'b0);

    // Clock edge: grant capture, writeback, load.
    ld_ok   = ld_valid && !m_busy[ld_ch];
    exp_iss = (g >= 0);
    if (g >= 0) begin
      sb       = req_sb[g*64 +: 64];
      exp_init = req_first[g];
      exp_sb   = sb;
      exp_st   = m_state[g];
      m_ret[g] = f_st(m_state[g], sb, req_first[g]);
      cbq.push_back('{cyc + CB_LAT + 1, g, f_cb(m_state[g], sb, req_first[g])});
      m_rr = (g + 1) % NCH;
    end
    for (int c = 0; c < NCH; c++)
      if (m_busy[c] && m_wb[c] == cyc) begin
        m_state[c] = m_ret[c];
        m_busy[c]  = 0;
      end
    if (ld_ok) begin
      m_state[ld_ch]  = ld_state;
      m_loaded[ld_ch] = 1;
    end
    if (g >= 0) begin
      m_busy[g] = 1;
      m_wb[g]   = cyc + ST_LAT;
    end
  endtask

  task automatic run(input int n, input int ld_pct, input bit stall);
    logic [127:0] r;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cyc++;
      r = {$urandom, $urandom, $urandom, $urandom};
      ld_valid  = !stall && ($urandom_range(99) < ld_pct);
      ld_ch     = CW'($urandom_range(NCH - 1));
      ld_state  = r[106:0];
      req_valid = stall ? '1 : NCH'($urandom | $urandom);
      req_first = NCH'($urandom);
      for (int c = 0; c < NCH; c++) req_sb[c*64 +: 64] = {$urandom, $urandom};
      @(negedge clk);
      step();
    end
  endtask

  // Asserted mid-cycle, so any blocks in flight are abandoned.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; ld_valid = 1'b0; req_valid = '1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cb_valid", cb_valid, 0);
    chk("rst_cb_ch", cb_ch, 0);
    chk("rst_cb_data", cb_data, 0);
    chk("rst_pl_init", pl_init, 0);
    chk("rst_pl_sb", pl_sb, 0);
    chk("rst_pl_state", pl_state_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    ld_valid = 0; ld_ch = '0; ld_state = '0;
    req_valid = '0; req_first = '0; req_sb = '0;
    model_clear();
    do_reset();
    run(400, 30, 0);
    run(800, 8, 0);
    do_reset();
    run(2*CB_LAT + 4, 0, 1);
    run(600, 20, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
